// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and the fetch buffer entry type for the cpu front end.
//   ADDR_W        PROM address / PC width
//   INST_W        instruction word width
//   fetch_entry_t {pc, inst} pair held in the fetch buffer
package cpu_pkg;
    localparam int ADDR_W = 16;
    localparam int INST_W = 32;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with a flush that beats push.
//   push/push_data  write an entry at the tail
//   pop             drop the head entry
//   flush           empty the buffer; overrides push and pop
//   count           current occupancy (0..DEPTH)
//   head            head entry, zero while empty
//   empty           no entries held
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end
    assign empty = count == '0;
    assign head  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues PROM reads and buffers fetched words for decode.
//   prom_addr/prom_data          PROM read port, data one cycle after address
//   redirect_valid/redirect_addr core PC change; flushes buffered and inflight words
//   halt                         stops new issue, buffer keeps draining
//   instruction/inst_pc/inst_valid/inst_ready  valid/ready handshake to decode
module fetch_unit #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INST_W   = cpu_pkg::INST_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] prom_addr,
    input  logic [INST_W-1:0] prom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt,
    output logic [INST_W-1:0] instruction,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready
);
    import cpu_pkg::*;
    localparam int CW = $clog2(DEPTH);
    logic [ADDR_W-1:0] fetch_pc, inflight_pc;
    logic              inflight, issue, pop, empty;
    logic [CW:0]       count;
    fetch_entry_t      entry, head;
    assign pop   = inst_valid & inst_ready;
    // Reserve a buffer slot for every outstanding read so a capture never hits a full FIFO.
    assign issue = !redirect_valid && !halt && (int'(count) + int'(inflight) - int'(pop) < DEPTH);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= fetch_pc;
            fetch_pc <= redirect_valid ? redirect_addr : issue ? fetch_pc + ADDR_W'(1) : fetch_pc;
        end
    end
    assign entry = '{pc: inflight_pc, inst: prom_data};
    // A redirect flushes the buffer, which also discards the word captured in the same cycle.
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head),
        .empty     (empty)
    );
    assign prom_addr   = fetch_pc;
    assign inst_valid  = !empty;
    assign instruction = head.inst;
    assign inst_pc     = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand sequences for fetch_unit.
module tb_fetch_unit;
    typedef struct {
        logic        rst, rdy, redir;
        logic [15:0] raddr;
        logic        halt, ev;
        logic [15:0] epc, eaddr;
    } vec_t;

    logic        clk = 0;
    logic        reset = 1, redirect_valid = 0, halt = 0, inst_ready = 0;
    logic [15:0] redirect_addr = '0, prom_addr, inst_pc;
    logic [31:0] prom_data, instruction;
    logic        inst_valid;

    logic        reset_b = 1, rdy_b = 0, redir_b = 0, halt_b = 0;
    logic [15:0] raddr_b = '0, prom_addr_b, inst_pc_b;
    logic [31:0] prom_data_b, instruction_b;
    logic        inst_valid_b;

    int checks = 0, passed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(posedge clk) prom_data   <= 32'hA000_0000 + {16'h0, prom_addr};
    always @(posedge clk) prom_data_b <= 32'hA000_0000 + {16'h0, prom_addr_b};

    fetch_unit dut (
        .clk(clk), .reset(reset), .prom_addr(prom_addr), .prom_data(prom_data),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt(halt),
        .instruction(instruction), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .reset(reset_b), .prom_addr(prom_addr_b), .prom_data(prom_data_b),
        .redirect_valid(redir_b), .redirect_addr(raddr_b), .halt(halt_b),
        .instruction(instruction_b), .inst_pc(inst_pc_b), .inst_valid(inst_valid_b), .inst_ready(rdy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic rst, rdy, redir, input logic [15:0] raddr, input logic hlt, ev,
                       input logic [15:0] epc, eaddr);
        vecs.push_back('{rst, rdy, redir, raddr, hlt, ev, epc, eaddr});
    endtask

    initial begin
        int k, first_cyc;
        logic [15:0] exp_b [4];
        // reset, then streaming with ready high
        add(1,1,0,16'h0000,0, 0,16'h0000,16'h0000);
        add(0,1,0,16'h0000,0, 0,16'h0000,16'h0000);
        add(0,1,0,16'h0000,0, 0,16'h0000,16'h0001);
        add(0,1,0,16'h0000,0, 1,16'h0000,16'h0002);
        add(0,1,0,16'h0000,0, 1,16'h0001,16'h0003);
        add(0,1,0,16'h0000,0, 1,16'h0002,16'h0004);
        add(0,1,0,16'h0000,0, 1,16'h0003,16'h0005);
        // reset, then ready low for 10 cycles: buffer fills, address freezes at 4
        add(1,0,0,16'h0000,0, 0,16'h0000,16'h0000);
        add(0,0,0,16'h0000,0, 0,16'h0000,16'h0000);
        add(0,0,0,16'h0000,0, 0,16'h0000,16'h0001);
        add(0,0,0,16'h0000,0, 1,16'h0000,16'h0002);
        add(0,0,0,16'h0000,0, 1,16'h0000,16'h0003);
        for (int i = 0; i < 6; i++) add(0,0,0,16'h0000,0, 1,16'h0000,16'h0004);
        // drain: PCs 0..5 with no gap
        add(0,1,0,16'h0000,0, 1,16'h0000,16'h0004);
        add(0,1,0,16'h0000,0, 1,16'h0001,16'h0005);
        add(0,1,0,16'h0000,0, 1,16'h0002,16'h0006);
        add(0,1,0,16'h0000,0, 1,16'h0003,16'h0007);
        add(0,1,0,16'h0000,0, 1,16'h0004,16'h0008);
        add(0,1,0,16'h0000,0, 1,16'h0005,16'h0009);
        // redirect with 3 buffered + 1 inflight
        add(0,1,1,16'h0100,0, 1,16'h0006,16'h000A);
        add(0,1,0,16'h0000,0, 0,16'h0000,16'h0100);
        add(0,1,0,16'h0000,0, 0,16'h0000,16'h0101);
        add(0,1,0,16'h0000,0, 1,16'h0100,16'h0102);
        add(0,1,0,16'h0000,0, 1,16'h0101,16'h0103);
        // back-to-back redirects, last wins
        add(0,1,1,16'h0200,0, 1,16'h0102,16'h0104);
        add(0,1,1,16'h0300,0, 0,16'h0000,16'h0200);
        add(0,1,0,16'h0000,0, 0,16'h0000,16'h0300);
        add(0,1,0,16'h0000,0, 0,16'h0000,16'h0301);
        add(0,1,0,16'h0000,0, 1,16'h0300,16'h0302);
        // halt with one inflight: it is still delivered, address holds
        add(0,1,0,16'h0000,1, 1,16'h0301,16'h0303);
        add(0,1,0,16'h0000,1, 1,16'h0302,16'h0303);
        add(0,1,0,16'h0000,1, 0,16'h0000,16'h0303);
        add(0,1,0,16'h0000,1, 0,16'h0000,16'h0303);
        add(0,1,0,16'h0000,0, 0,16'h0000,16'h0303);
        add(0,1,0,16'h0000,0, 0,16'h0000,16'h0304);
        add(0,1,0,16'h0000,0, 1,16'h0303,16'h0305);
        // redirect during halt
        add(0,1,1,16'h0040,1, 1,16'h0304,16'h0306);
        add(0,1,0,16'h0000,1, 0,16'h0000,16'h0040);
        add(0,1,0,16'h0000,0, 0,16'h0000,16'h0040);
        add(0,1,0,16'h0000,0, 0,16'h0000,16'h0041);
        add(0,1,0,16'h0000,0, 1,16'h0040,16'h0042);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            reset          = vecs[i].rst;
            inst_ready     = vecs[i].rdy;
            redirect_valid = vecs[i].redir;
            redirect_addr  = vecs[i].raddr;
            halt           = vecs[i].halt;
            @(negedge clk);
            check($sformatf("v%0d valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].ev});
            check($sformatf("v%0d pc", i), {16'h0, inst_pc}, {16'h0, vecs[i].epc});
            check($sformatf("v%0d inst", i), instruction,
                  vecs[i].ev ? 32'hA000_0000 + {16'h0, vecs[i].epc} : 32'h0);
            check($sformatf("v%0d addr", i), {16'h0, prom_addr}, {16'h0, vecs[i].eaddr});
        end

        // async reset mid-stream, observed before the next clock edge
        @(posedge clk); #1;
        check("pre_rst valid", {31'b0, inst_valid}, 32'd1);
        check("pre_rst pc", {16'h0, inst_pc}, 32'h0041);
        #1 reset = 1;
        #1;
        check("async_rst valid", {31'b0, inst_valid}, 32'd0);
        check("async_rst addr", {16'h0, prom_addr}, 32'h0);
        check("async_rst pc", {16'h0, inst_pc}, 32'h0);
        check("async_rst inst", instruction, 32'h0);

        // RESET_PC near the top of the address space wraps to 0
        exp_b = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        @(posedge clk); #1;
        reset_b = 0;
        rdy_b   = 1;
        k = 0;
        first_cyc = -1;
        for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
            @(negedge clk);
            if (inst_valid_b) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    check("wrap first_cycle", first_cyc, 32'd2);
                end
                check($sformatf("wrap pc%0d", k), {16'h0, inst_pc_b}, {16'h0, exp_b[k]});
                check($sformatf("wrap inst%0d", k), instruction_b, 32'hA000_0000 + {16'h0, exp_b[k]});
                k++;
            end
        end
        check("wrap count", k, 32'd4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the cpu core.
- Owns the program counter and drives the program ROM address.
- Captures ROM data one cycle later and buffers fetched words with their PCs in a small FIFO.
- Presents words to the core's decode over a valid/ready handshake.
- Accepts PC redirects (jumps, taken branches) from the core and flushes stale fetches.

Parameters:
ADDR_W, 16, PROM address / PC width
INST_W, 32, instruction word width
DEPTH, 4, fetch buffer entries; power of two, >= 2
RESET_PC, 16'h0000, PC loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
prom_addr  output  ADDR_W  ROM read address; registered (equals fetch_pc)
prom_data  input  INST_W  ROM read data; valid the cycle after prom_addr was issued
redirect_valid  input  1  core requests PC change this cycle
redirect_addr  input  ADDR_W  new fetch target
halt  input  1  suppress new fetch issue
instruction  output  INST_W  head-of-buffer instruction word
inst_pc  output  ADDR_W  PC of head instruction
inst_valid  output  1  head entry valid
inst_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (async assert, sync release): fetch_pc = RESET_PC, so prom_addr = RESET_PC. FIFO is empty and inst_valid = 0. inflight = 0. instruction and inst_pc read 0.
- Issue rule: issue in cycle t when
  - !redirect_valid, and
  - !halt, and
  - count + inflight - pop < DEPTH, where pop = inst_valid & inst_ready.
- On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 1. The increment is modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000.
- No issue: inflight <= 0 and fetch_pc holds.
- Capture: in cycle t+1 after an issue, {inflight_pc, prom_data} is pushed into the FIFO at the clock edge ending t+1.
- Latency: from reset release, the first word is issued in cycle 0 and inst_valid = 1 in cycle 2. Address issue to inst_valid is 2 cycles.
- Throughput: 1 instruction/cycle sustained while inst_ready stays high.
- Handshake:
  - instruction and inst_pc are driven from the FIFO head and stay stable while inst_valid & !inst_ready.
  - inst_valid never deasserts without a pop or a redirect.
- Simultaneous push and pop: allowed at any occupancy, including full (count == DEPTH). The issue rule guarantees there is never a push to a full FIFO without a pop.
- Redirect in cycle t:
  - FIFO is flushed and the inflight response arriving in t+1 is discarded. Any pop in cycle t still counts as consumed.
  - No issue in t; fetch_pc <= redirect_addr.
  - prom_addr = redirect_addr in t+1 and the target is issued then, unless halt is high.
  - inst_valid = 1 with inst_pc = redirect_addr in t+3.
- Back-to-back redirects: the last redirect wins and each one flushes.
- Halt: stops issue only. The inflight word is still captured and the FIFO drains normally. Redirect during halt still updates fetch_pc and flushes.
- Reset mid-operation: all state returns immediately to its reset values and any inflight data is dropped.

Decomposition:
- Shared package cpu_pkg holds:
  - the ADDR_W and INST_W constants;
  - fetch_entry_t, a packed struct {logic [ADDR_W-1:0] pc; logic [INST_W-1:0] inst;}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH.
  - Ports: push, pop, flush, count, head, empty.
  - flush has priority over push.
- The PC, issue and inflight logic stays in fetch_unit.

Test Plan:
1. Reset release, ROM[i] = 32'hA000_0000+i, inst_ready = 1 -> inst_valid rises in cycle 2 with inst_pc 0 and instruction A000_0000, then PCs 1, 2, 3 on consecutive cycles.
2. inst_ready = 0 for 10 cycles -> exactly DEPTH=4 entries buffered and prom_addr frozen at 4. Raise ready -> PCs 0..3 then 4 follow with no gap or duplicate.
3. Redirect to 16'h0100 while the FIFO holds 3 entries plus one inflight -> inst_valid drops next cycle, prom_addr = 0x0100 in t+1, and the first delivered inst_pc is 0x0100 in t+3.
4. RESET_PC = 16'hFFFE, inst_ready = 1 -> delivered PCs are FFFE, FFFF, 0000, 0001.
5. Assert halt with one inflight -> that word is still delivered, and prom_addr stays constant with no new pushes. Deassert halt -> fetch resumes at the next sequential PC.
6. Assert reset asynchronously mid-stream with the FIFO non-empty -> inst_valid = 0 and prom_addr = RESET_PC immediately, before the next clock edge.
